// File: rtl/ex_mem_wb_path.sv
// EX/MEM and MEM/WB pipeline registers with a 64-word data memory between them.
// Drives the branch redirect to fetch and the register-file write port.
module ex_mem_wb_path (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic        ex_branch,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [31:0] ex_pc_branch,
    input  logic        ex_alu_zero,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_rt_data,
    input  logic [4:0]  ex_write_reg,
    output logic        pc_src,
    output logic [31:0] pc_branch,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_write_reg,
    output logic [31:0] wb_write_data,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_res
);

    // EX/MEM register
    logic        mem_valid_q,      mem_valid_d;
    logic        mem_reg_write_q,  mem_reg_write_d;
    logic        mem_mem_to_reg_q, mem_mem_to_reg_d;
    logic        mem_branch_q,     mem_branch_d;
    logic        mem_mem_read_q,   mem_mem_read_d;
    logic        mem_mem_write_q,  mem_mem_write_d;
    logic [31:0] mem_pc_branch_q,  mem_pc_branch_d;
    logic        mem_alu_zero_q,   mem_alu_zero_d;
    logic [31:0] mem_alu_res_q,    mem_alu_res_d;
    logic [31:0] mem_rt_data_q,    mem_rt_data_d;
    logic [4:0]  mem_write_reg_q,  mem_write_reg_d;

    // MEM/WB register
    logic        wb_valid_q,       wb_valid_d;
    logic        wb_reg_write_q,   wb_reg_write_d;
    logic        wb_mem_to_reg_q,  wb_mem_to_reg_d;
    logic [4:0]  wb_write_reg_q,   wb_write_reg_d;
    logic [31:0] wb_alu_res_q,     wb_alu_res_d;
    logic [31:0] wb_read_data_q,   wb_read_data_d;

    // Data memory
    logic [31:0] dmem_q [64];
    logic [31:0] dmem_d [64];
    logic [5:0]  dmem_addr;
    logic [31:0] dmem_rdata;
    logic        dmem_we;

    assign dmem_addr  = mem_alu_res_q[7:2];
    assign dmem_rdata = dmem_q[dmem_addr];
    assign dmem_we    = mem_valid_q & mem_mem_write_q & ~stall;

    always_comb begin
        mem_valid_d      = mem_valid_q;
        mem_reg_write_d  = mem_reg_write_q;
        mem_mem_to_reg_d = mem_mem_to_reg_q;
        mem_branch_d     = mem_branch_q;
        mem_mem_read_d   = mem_mem_read_q;
        mem_mem_write_d  = mem_mem_write_q;
        mem_pc_branch_d  = mem_pc_branch_q;
        mem_alu_zero_d   = mem_alu_zero_q;
        mem_alu_res_d    = mem_alu_res_q;
        mem_rt_data_d    = mem_rt_data_q;
        mem_write_reg_d  = mem_write_reg_q;
        // Flush wins over stall; datapath fields of a bubble are loaded but never consumed.
        if (flush || !stall) begin
            mem_valid_d      = ex_valid      & ~flush;
            mem_reg_write_d  = ex_reg_write  & ~flush;
            mem_mem_to_reg_d = ex_mem_to_reg & ~flush;
            mem_branch_d     = ex_branch     & ~flush;
            mem_mem_read_d   = ex_mem_read   & ~flush;
            mem_mem_write_d  = ex_mem_write  & ~flush;
            mem_pc_branch_d  = ex_pc_branch;
            mem_alu_zero_d   = ex_alu_zero;
            mem_alu_res_d    = ex_alu_res;
            mem_rt_data_d    = ex_rt_data;
            mem_write_reg_d  = ex_write_reg;
        end
    end

    always_comb begin
        wb_valid_d      = wb_valid_q;
        wb_reg_write_d  = wb_reg_write_q;
        wb_mem_to_reg_d = wb_mem_to_reg_q;
        wb_write_reg_d  = wb_write_reg_q;
        wb_alu_res_d    = wb_alu_res_q;
        wb_read_data_d  = wb_read_data_q;
        if (!stall) begin
            wb_valid_d      = mem_valid_q;
            wb_reg_write_d  = mem_reg_write_q;
            wb_mem_to_reg_d = mem_mem_to_reg_q;
            wb_write_reg_d  = mem_write_reg_q;
            wb_alu_res_d    = mem_alu_res_q;
            wb_read_data_d  = mem_mem_read_q ? dmem_rdata : '0;
        end
    end

    always_comb begin
        dmem_d = dmem_q;
        if (dmem_we) begin
            dmem_d[dmem_addr] = mem_rt_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid_q      <= 1'b0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            mem_branch_q     <= 1'b0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_pc_branch_q  <= '0;
            mem_alu_zero_q   <= 1'b0;
            mem_alu_res_q    <= '0;
            mem_rt_data_q    <= '0;
            mem_write_reg_q  <= '0;
            wb_valid_q       <= 1'b0;
            wb_reg_write_q   <= 1'b0;
            wb_mem_to_reg_q  <= 1'b0;
            wb_write_reg_q   <= '0;
            wb_alu_res_q     <= '0;
            wb_read_data_q   <= '0;
        end else begin
            mem_valid_q      <= mem_valid_d;
            mem_reg_write_q  <= mem_reg_write_d;
            mem_mem_to_reg_q <= mem_mem_to_reg_d;
            mem_branch_q     <= mem_branch_d;
            mem_mem_read_q   <= mem_mem_read_d;
            mem_mem_write_q  <= mem_mem_write_d;
            mem_pc_branch_q  <= mem_pc_branch_d;
            mem_alu_zero_q   <= mem_alu_zero_d;
            mem_alu_res_q    <= mem_alu_res_d;
            mem_rt_data_q    <= mem_rt_data_d;
            mem_write_reg_q  <= mem_write_reg_d;
            wb_valid_q       <= wb_valid_d;
            wb_reg_write_q   <= wb_reg_write_d;
            wb_mem_to_reg_q  <= wb_mem_to_reg_d;
            wb_write_reg_q   <= wb_write_reg_d;
            wb_alu_res_q     <= wb_alu_res_d;
            wb_read_data_q   <= wb_read_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 64; i++) begin
                dmem_q[i] <= '0;
            end
        end else begin
            dmem_q <= dmem_d;
        end
    end

    assign pc_src        = mem_valid_q & mem_branch_q & mem_alu_zero_q;
    assign pc_branch     = mem_pc_branch_q;
    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_valid_q & wb_reg_write_q & (wb_write_reg_q != '0);
    assign wb_write_reg  = wb_write_reg_q;
    assign wb_read_data  = wb_read_data_q;
    assign wb_alu_res    = wb_alu_res_q;
    assign wb_write_data = wb_mem_to_reg_q ? wb_read_data_q : wb_alu_res_q;

endmodule

// File: tb/tb_ex_mem_wb_path.sv
// Directed bench for ex_mem_wb_path: ALU, store/load, branch, stall, flush, reset.
module tb_ex_mem_wb_path;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic        ex_branch;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [31:0] ex_pc_branch;
    logic        ex_alu_zero;
    logic [31:0] ex_alu_res;
    logic [31:0] ex_rt_data;
    logic [4:0]  ex_write_reg;
    logic        pc_src;
    logic [31:0] pc_branch;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic [31:0] wb_read_data;
    logic [31:0] wb_alu_res;

    int unsigned n_checks;
    int unsigned n_fail;

    ex_mem_wb_path dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_branch     (ex_branch),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_pc_branch  (ex_pc_branch),
        .ex_alu_zero   (ex_alu_zero),
        .ex_alu_res    (ex_alu_res),
        .ex_rt_data    (ex_rt_data),
        .ex_write_reg  (ex_write_reg),
        .pc_src        (pc_src),
        .pc_branch     (pc_branch),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_write_data (wb_write_data),
        .wb_read_data  (wb_read_data),
        .wb_alu_res    (wb_alu_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic rw, input logic m2r, input logic br,
                          input logic mr, input logic mw, input logic [31:0] pcb,
                          input logic zero, input logic [31:0] alu, input logic [31:0] rt,
                          input logic [4:0] wr);
        ex_valid      = v;
        ex_reg_write  = rw;
        ex_mem_to_reg = m2r;
        ex_branch     = br;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
        ex_pc_branch  = pcb;
        ex_alu_zero   = zero;
        ex_alu_res    = alu;
        ex_rt_data    = rt;
        ex_write_reg  = wr;
    endtask

    task automatic nop();
        set_ex(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pc_src"},     {31'h0, pc_src},       32'h0);
        check_eq({tag, "_pc_branch"},  pc_branch,             32'h0);
        check_eq({tag, "_wb_valid"},   {31'h0, wb_valid},     32'h0);
        check_eq({tag, "_wb_rw"},      {31'h0, wb_reg_write}, 32'h0);
        check_eq({tag, "_wb_wr"},      {27'h0, wb_write_reg}, 32'h0);
        check_eq({tag, "_wb_wdata"},   wb_write_data,         32'h0);
        check_eq({tag, "_wb_rdata"},   wb_read_data,          32'h0);
        check_eq({tag, "_wb_alu"},     wb_alu_res,            32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        nop();
        repeat (2) tick();
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // ALU result reaches writeback two edges later
        set_ex(1, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0000_002A, 32'h0, 5'd5);
        tick();
        nop();
        check_eq("alu_pc_src", {31'h0, pc_src}, 32'h0);
        check_eq("alu_wb_valid_early", {31'h0, wb_valid}, 32'h0);
        tick();
        check_eq("alu_wb_valid", {31'h0, wb_valid},     32'h1);
        check_eq("alu_wb_rw",    {31'h0, wb_reg_write}, 32'h1);
        check_eq("alu_wb_wr",    {27'h0, wb_write_reg}, 32'd5);
        check_eq("alu_wb_wdata", wb_write_data,         32'h2A);
        check_eq("alu_wb_rdata", wb_read_data,          32'h0);

        // Writes to r0 are suppressed
        set_ex(1, 1, 0, 0, 0, 0, 32'h0, 0, 32'h7, 32'h0, 5'd0);
        tick();
        nop();
        tick();
        check_eq("r0_wb_valid", {31'h0, wb_valid},     32'h1);
        check_eq("r0_wb_rw",    {31'h0, wb_reg_write}, 32'h0);

        // Store immediately followed by a load to the same word
        set_ex(1, 0, 0, 0, 0, 1, 32'h0, 0, 32'h10, 32'hDEAD_BEEF, 5'd0);
        tick();
        set_ex(1, 1, 1, 0, 1, 0, 32'h0, 0, 32'h10, 32'h0, 5'd8);
        tick();
        check_eq("st_wb_rw", {31'h0, wb_reg_write}, 32'h0);
        nop();
        tick();
        check_eq("ld_wdata", wb_write_data,         32'hDEAD_BEEF);
        check_eq("ld_rw",    {31'h0, wb_reg_write}, 32'h1);
        check_eq("ld_wr",    {27'h0, wb_write_reg}, 32'd8);

        // Upper and byte-offset address bits are ignored
        set_ex(1, 1, 1, 0, 1, 0, 32'h0, 0, 32'hABCD_0011, 32'h0, 5'd10);
        tick();
        nop();
        tick();
        check_eq("alias_rdata", wb_read_data, 32'hDEAD_BEEF);
        check_eq("alias_alu",   wb_alu_res,   32'hABCD_0011);

        // Read data is zero when mem_read is low
        set_ex(1, 1, 0, 0, 0, 0, 32'h0, 0, 32'h10, 32'h0, 5'd11);
        tick();
        nop();
        tick();
        check_eq("nord_rdata", wb_read_data,  32'h0);
        check_eq("nord_wdata", wb_write_data, 32'h10);

        // Branch taken, then flush in the same cycle keeps the redirect
        set_ex(1, 0, 0, 1, 0, 0, 32'h0000_0040, 1, 32'h0, 32'h0, 5'd0);
        tick();
        check_eq("br_pc_src",    {31'h0, pc_src}, 32'h1);
        check_eq("br_pc_branch", pc_branch,       32'h40);
        set_ex(1, 0, 0, 1, 0, 0, 32'h0000_0060, 1, 32'h0, 32'h0, 5'd0);
        flush = 1'b1;
        #1;
        check_eq("flushbr_pc_src", {31'h0, pc_src}, 32'h1);
        tick();
        flush = 1'b0;
        check_eq("flushbr_bubble", {31'h0, pc_src}, 32'h0);

        // Branch not taken, and a taken branch in an invalid slot
        set_ex(1, 0, 0, 1, 0, 0, 32'h0000_0080, 0, 32'h0, 32'h0, 5'd0);
        tick();
        check_eq("nt_pc_src",    {31'h0, pc_src}, 32'h0);
        check_eq("nt_pc_branch", pc_branch,       32'h80);
        set_ex(0, 0, 0, 1, 0, 0, 32'h0000_0090, 1, 32'h0, 32'h0, 5'd0);
        tick();
        check_eq("inv_pc_src",    {31'h0, pc_src}, 32'h0);
        check_eq("inv_pc_branch", pc_branch,       32'h90);

        // Stall with a store in EX/MEM holds everything for three cycles
        set_ex(1, 1, 0, 0, 0, 0, 32'h0, 0, 32'h33, 32'h0, 5'd3);
        tick();
        set_ex(1, 0, 0, 0, 0, 1, 32'h0000_1234, 0, 32'h24, 32'h55AA_55AA, 5'd0);
        tick();
        stall = 1'b1;
        set_ex(1, 1, 1, 0, 1, 0, 32'h0, 0, 32'h24, 32'h0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_pc_branch", pc_branch,             32'h1234);
            check_eq("stall_wb_wr",     {27'h0, wb_write_reg}, 32'd3);
            check_eq("stall_wb_wdata",  wb_write_data,         32'h33);
            check_eq("stall_wb_rw",     {31'h0, wb_reg_write}, 32'h1);
        end
        stall = 1'b0;
        tick();
        check_eq("rel_wb_rw",  {31'h0, wb_reg_write}, 32'h0);
        check_eq("rel_wb_alu", wb_alu_res,            32'h24);
        nop();
        tick();
        check_eq("rel_ld_wdata", wb_write_data, 32'h55AA_55AA);
        check_eq("rel_ld_wr",    {27'h0, wb_write_reg}, 32'd9);

        // Flushed store never writes and never reaches writeback
        set_ex(1, 1, 0, 0, 0, 1, 32'h0, 0, 32'h28, 32'hCAFE_F00D, 5'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_ex(1, 1, 1, 0, 1, 0, 32'h0, 0, 32'h28, 32'h0, 5'd12);
        tick();
        check_eq("flush_wb_valid", {31'h0, wb_valid},     32'h0);
        check_eq("flush_wb_rw",    {31'h0, wb_reg_write}, 32'h0);
        nop();
        tick();
        check_eq("flush_ld_wdata", wb_write_data, 32'h0);

        // Asynchronous reset with a store sitting in EX/MEM
        set_ex(1, 1, 0, 0, 0, 0, 32'h0, 0, 32'h77, 32'h0, 5'd4);
        tick();
        set_ex(1, 0, 0, 0, 0, 1, 32'h0000_0050, 0, 32'h30, 32'h0000_0099, 5'd0);
        tick();
        check_eq("pre_rst_pc_branch", pc_branch, 32'h50);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        @(negedge clk);
        rst = 1'b1;
        set_ex(1, 1, 1, 0, 1, 0, 32'h0, 0, 32'h30, 32'h0, 5'd13);
        tick();
        set_ex(1, 1, 1, 0, 1, 0, 32'h0, 0, 32'h10, 32'h0, 5'd14);
        tick();
        check_eq("post_rst_ld30", wb_write_data, 32'h0);
        nop();
        tick();
        check_eq("post_rst_ld10", wb_write_data, 32'h0);
        check_eq("post_rst_wr",   {27'h0, wb_write_reg}, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
